// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-control blocks:
//   - one-hot car lamp codes   (C_RED, C_YELLOW, C_LEFT, C_GREEN, C_NONE)
//   - one-hot walker lamp codes (W_RED, W_GREEN, W_NONE)
//   - sched_state_t: 3-bit state encoding of the intersection scheduler
//   - lamp_set_t / lamps_for(): lamp decode for a given scheduler state
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [3:0] C_RED    = 4'b1000;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_LEFT   = 4'b0010;
    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_NONE   = 4'b0000;

    localparam logic [1:0] W_RED    = 2'b10;
    localparam logic [1:0] W_GREEN  = 2'b01;
    localparam logic [1:0] W_NONE   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MG     = 3'd1,
        ST_MY     = 3'd2,
        ST_AR     = 3'd3,
        ST_SG     = 3'd4,
        ST_SY     = 3'd5,
        ST_WALK   = 3'd6,
        ST_WFLASH = 3'd7
    } sched_state_t;

    typedef struct packed {
        logic [3:0] main;
        logic [3:0] side;
        logic [1:0] walk;
    } lamp_set_t;

    // Lamp pattern for a state; flash_phase=1 blanks the walker during WFLASH.
    function automatic lamp_set_t lamps_for(input sched_state_t st, input logic flash_phase);
        lamp_set_t l;
        l = '{main: C_NONE, side: C_NONE, walk: W_NONE};
        case (st)
            ST_IDLE:   l = '{main: C_NONE,   side: C_NONE,   walk: W_NONE};
            ST_MG:     l = '{main: C_GREEN,  side: C_RED,    walk: W_RED};
            ST_MY:     l = '{main: C_YELLOW, side: C_RED,    walk: W_RED};
            ST_AR:     l = '{main: C_RED,    side: C_RED,    walk: W_RED};
            ST_SG:     l = '{main: C_RED,    side: C_GREEN,  walk: W_RED};
            ST_SY:     l = '{main: C_RED,    side: C_YELLOW, walk: W_RED};
            ST_WALK:   l = '{main: C_RED,    side: C_RED,    walk: W_GREEN};
            ST_WFLASH: l = '{main: C_RED,    side: C_RED,
                             walk: (flash_phase ? W_NONE : W_GREEN)};
            default:   l = '{main: C_NONE,   side: C_NONE,   walk: W_NONE};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_sched_if.sv
// -----------------------------------------------------------------------------
// intersection_sched_if
// Request inputs and lamp/status outputs of the intersection scheduler.
//   i_enable       scheduler run (0 forces IDLE)
//   i_side_req     side-road car sensor, level
//   i_ped_req      pedestrian button, level or pulse
//   o_main/o_side  car lamps, one-hot (RED/YELLOW/LEFT/GREEN)
//   o_walk         walker lamp, one-hot (RED/GREEN)
//   o_state        current scheduler state, for debug
//   o_ped_pending  pedestrian request latched ("wait" lamp)
// master: the request source / lamp consumer; slave: the scheduler.
// -----------------------------------------------------------------------------
interface intersection_sched_if;
    logic       i_enable;
    logic       i_side_req;
    logic       i_ped_req;
    logic [3:0] o_main;
    logic [3:0] o_side;
    logic [1:0] o_walk;
    logic [2:0] o_state;
    logic       o_ped_pending;

    modport master (
        output i_enable, i_side_req, i_ped_req,
        input  o_main, o_side, o_walk, o_state, o_ped_pending
    );

    modport slave (
        input  i_enable, i_side_req, i_ped_req,
        output o_main, o_side, o_walk, o_state, o_ped_pending
    );
endinterface

// File: rtl/intersection_sched_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler counting 0..TICK_DIV-1; tick is high for the cycle in which the
// count sits at TICK_DIV-1. A synchronous clr restarts the count at 0.
//   clk      clock
//   reset_n  synchronous active-low reset
//   clr      synchronous restart of the prescaler
//   tick     one-cycle strobe every TICK_DIV cycles
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned       CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;

    // Next prescaler value: restart on clr, wrap after the last count.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_next_s = CNT_ZERO;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Count register; tick is registered alongside so it always equals (cnt_r == CNT_LAST).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= (CNT_LAST == CNT_ZERO);
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= (cnt_next_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/intersection_sched.sv
// -----------------------------------------------------------------------------
// intersection_sched
// Phase scheduler for a main road, a side road and a pedestrian crossing.
// Main road rests on green; the side road is served only on request, and a
// pedestrian request gets an exclusive WALK phase followed by a flashing
// clearance. All lamp outputs are registered and follow the state register.
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      intersection_sched_if.slave: requests in, lamps/status out
// Timing parameters are in seconds of TICK_DIV clk cycles each.
// -----------------------------------------------------------------------------
module intersection_sched
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned MIN_GREEN = 10,
    parameter int unsigned MAX_GREEN = 30,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 8,
    parameter int unsigned FLASH_T   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    intersection_sched_if.slave  bus
);

    // Limits compared against sec+1, kept one bit wider than sec so that
    // sec=255 cannot wrap the comparison.
    localparam logic [8:0] L_MIN    = 9'(MIN_GREEN);
    localparam logic [8:0] L_MAX    = 9'(MAX_GREEN);
    localparam logic [8:0] L_YELLOW = 9'(YELLOW_T);
    localparam logic [8:0] L_ALLRED = 9'(ALLRED_T);
    localparam logic [8:0] L_WALK   = 9'(WALK_T);
    localparam logic [8:0] L_FLASH  = 9'(FLASH_T);

    sched_state_t state_r;
    sched_state_t state_next_s;
    logic [7:0]   sec_r;
    logic [7:0]   sec_next_s;
    logic [8:0]   sec_p1_s;
    logic         tick_s;
    logic         tick_clr_s;
    logic         state_chg_s;
    logic         enter_sg_s;
    logic         enter_mg_s;
    logic         enter_walk_s;
    logic         side_pend_r;
    logic         side_pend_next_s;
    logic         ped_pend_r;
    logic         ped_pend_next_s;
    logic         last_side_r;
    logic         last_side_next_s;
    lamp_set_t    lamp_r;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tick_clr_s),
        .tick    (tick_s)
    );

    // Next-state logic; timed exits fire on the tick where sec+1 reaches the limit.
    always_comb begin
        state_next_s = state_r;
        sec_p1_s     = {1'b0, sec_r} + 9'd1;
        if (!bus.i_enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_MG;
                end
                ST_MG: begin
                    // MAX_GREEN deliberately plays no part here: main holds until
                    // MIN_GREEN has elapsed and somebody is waiting.
                    if (tick_s && (sec_p1_s >= L_MIN) && (side_pend_r || ped_pend_r)) begin
                        state_next_s = ST_MY;
                    end else begin
                        state_next_s = ST_MG;
                    end
                end
                ST_MY: begin
                    if (tick_s && (sec_p1_s >= L_YELLOW)) begin
                        state_next_s = ST_AR;
                    end else begin
                        state_next_s = ST_MY;
                    end
                end
                ST_AR: begin
                    if (tick_s && (sec_p1_s >= L_ALLRED)) begin
                        // Pedestrian first; the side road only right after a main phase.
                        if (ped_pend_r) begin
                            state_next_s = ST_WALK;
                        end else if (!last_side_r && side_pend_r) begin
                            state_next_s = ST_SG;
                        end else begin
                            state_next_s = ST_MG;
                        end
                    end else begin
                        state_next_s = ST_AR;
                    end
                end
                ST_SG: begin
                    // Gap-out once the sensor clears after MIN_GREEN, or max-out.
                    if (tick_s && (((sec_p1_s >= L_MIN) && !bus.i_side_req) ||
                                   (sec_p1_s >= L_MAX))) begin
                        state_next_s = ST_SY;
                    end else begin
                        state_next_s = ST_SG;
                    end
                end
                ST_SY: begin
                    if (tick_s && (sec_p1_s >= L_YELLOW)) begin
                        state_next_s = ST_AR;
                    end else begin
                        state_next_s = ST_SY;
                    end
                end
                ST_WALK: begin
                    if (tick_s && (sec_p1_s >= L_WALK)) begin
                        state_next_s = ST_WFLASH;
                    end else begin
                        state_next_s = ST_WALK;
                    end
                end
                ST_WFLASH: begin
                    if (tick_s && (sec_p1_s >= L_FLASH)) begin
                        state_next_s = ST_MG;
                    end else begin
                        state_next_s = ST_WFLASH;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State-entry strobes and prescaler restart (any state change or disable).
    always_comb begin
        state_chg_s  = (state_next_s != state_r);
        enter_sg_s   = state_chg_s && (state_next_s == ST_SG);
        enter_mg_s   = state_chg_s && (state_next_s == ST_MG);
        enter_walk_s = state_chg_s && (state_next_s == ST_WALK);
        tick_clr_s   = state_chg_s || !bus.i_enable;
    end

    // Elapsed seconds in the current state, saturating at 255.
    always_comb begin
        sec_next_s = sec_r;
        if (tick_clr_s) begin
            sec_next_s = 8'd0;
        end else if (tick_s && (sec_r != 8'hFF)) begin
            sec_next_s = sec_r + 8'd1;
        end else begin
            sec_next_s = sec_r;
        end
    end

    // Request latches and side-service memory; a clear always beats a set.
    always_comb begin
        side_pend_next_s = side_pend_r;
        ped_pend_next_s  = ped_pend_r;
        last_side_next_s = last_side_r;

        if (!bus.i_enable) begin
            side_pend_next_s = 1'b0;
        end else if (enter_sg_s) begin
            side_pend_next_s = 1'b0;
        end else if (bus.i_side_req && (state_r != ST_SG)) begin
            side_pend_next_s = 1'b1;
        end else begin
            side_pend_next_s = side_pend_r;
        end

        if (!bus.i_enable) begin
            ped_pend_next_s = 1'b0;
        end else if (enter_walk_s) begin
            ped_pend_next_s = 1'b0;
        end else if (bus.i_ped_req && (state_r != ST_WALK) && (state_r != ST_WFLASH)) begin
            ped_pend_next_s = 1'b1;
        end else begin
            ped_pend_next_s = ped_pend_r;
        end

        if (!bus.i_enable) begin
            last_side_next_s = 1'b0;
        end else if (enter_sg_s) begin
            last_side_next_s = 1'b1;
        end else if (enter_mg_s) begin
            last_side_next_s = 1'b0;
        end else begin
            last_side_next_s = last_side_r;
        end
    end

    // State, counters, latches and lamp registers. Lamps are decoded from the
    // next state so they change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            sec_r       <= 8'd0;
            side_pend_r <= 1'b0;
            ped_pend_r  <= 1'b0;
            last_side_r <= 1'b0;
            lamp_r      <= '{main: C_NONE, side: C_NONE, walk: W_NONE};
        end else begin
            state_r     <= state_next_s;
            sec_r       <= sec_next_s;
            side_pend_r <= side_pend_next_s;
            ped_pend_r  <= ped_pend_next_s;
            last_side_r <= last_side_next_s;
            lamp_r      <= lamps_for(state_next_s, sec_next_s[0]);
        end
    end

    assign bus.o_main        = lamp_r.main;
    assign bus.o_side        = lamp_r.side;
    assign bus.o_walk        = lamp_r.walk;
    assign bus.o_state       = state_r;
    assign bus.o_ped_pending = ped_pend_r;

endmodule
